// File: rtl/ram_rd_pkg.sv
// Shared types and constants for the block-RAM burst reader.
package ram_rd_pkg;

    // Burst controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // RAM read latency in cycles (registered address)
    localparam int RAM_RD_LAT = 1;
    // Number of words the skid buffer can hold
    localparam int SKID_DEPTH = 2;

    // Words committed to the output path after this cycle: stored + returning - leaving
    function automatic logic [2:0] fill_level(input logic [1:0] occ,
                                              input logic       inflight,
                                              input logic       pop);
        fill_level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry {last, data} buffer that absorbs RAM returns while the stream stalls.
module ram_rd_skid
    import ram_rd_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW:0]   i_din,
    output logic [DW:0]   o_head,
    output logic [1:0]    o_occ
);

    logic [DW:0] r_ent0;
    logic [DW:0] r_ent1;
    logic [1:0]  r_occ;

    // Entry storage and occupancy; entry 0 is always the oldest word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ent0 <= {(DW+1){1'b0}};
            r_ent1 <= {(DW+1){1'b0}};
            r_occ  <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_ent0 <= i_din;
                    end else begin
                        r_ent1 <= i_din;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_ent0 <= i_din;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_din;
                    end
                end
                default: begin
                    r_occ <= r_occ;
                end
            endcase
        end
    end

    assign o_head = r_ent0;
    assign o_occ  = r_occ;

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read initiator for a 1-cycle registered-address block RAM; returns words as a
// valid/ready stream with last. The word returning from the RAM is presented directly
// when the skid is empty, so the first beat appears two cycles after command accept.
module ram_burst_reader
    import ram_rd_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len_m1,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    input  logic [DW-1:0] ram_do,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);

    state_t        r_state;
    state_t        w_next_state;
    logic [AW:0]   r_beats_left;
    logic [AW-1:0] r_addr;
    logic          r_inflight;
    logic          r_inflight_last;

    logic          w_accept;
    logic          w_issue;
    logic          w_pop;
    logic          w_skid_push;
    logic          w_skid_pop;
    logic [1:0]    w_occ;
    logic [DW:0]   w_head;
    logic [2:0]    w_fill;

    // Words already stored or returning, minus the one leaving this cycle
    assign w_fill   = fill_level(w_occ, r_inflight, w_pop);
    assign w_accept = cmd_valid & cmd_ready;
    assign w_pop    = out_valid & out_ready;
    // Issue only while beats remain and the skid can take the word when it returns
    assign w_issue  = (r_state == ISSUE) && (r_beats_left != {(AW+1){1'b0}}) &&
                      (w_fill < 3'(SKID_DEPTH)) && !rst;
    // A returning word popped straight through never enters the skid
    assign w_skid_pop  = w_pop & (w_occ != 2'd0);
    assign w_skid_push = r_inflight & ~(w_pop & (w_occ == 2'd0));

    ram_rd_skid #(.DW(DW)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_skid_push),
        .i_pop  (w_skid_pop),
        .i_din  ({r_inflight_last, ram_do}),
        .o_head (w_head),
        .o_occ  (w_occ)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = ISSUE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ISSUE: begin
                if (w_issue && (r_beats_left == {{AW{1'b0}}, 1'b1})) begin
                    w_next_state = DRAIN;
                end else begin
                    w_next_state = ISSUE;
                end
            end
            DRAIN: begin
                if (w_pop && out_last) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DRAIN;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // FSM and stream outputs; the skid head has priority over the word arriving from the RAM
    always_comb begin
        cmd_ready = (r_state == IDLE) && !rst;
        busy      = (r_state != IDLE);
        ram_en    = w_issue;
        ram_we    = 1'b0;
        ram_a     = r_addr;
        out_valid = (w_occ != 2'd0) | r_inflight;
        if (w_occ != 2'd0) begin
            out_data = w_head[DW-1:0];
            out_last = w_head[DW];
        end else begin
            out_data = ram_do;
            out_last = r_inflight & r_inflight_last;
        end
    end

    // Address/beat counters and tracking of the read returning next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr          <= {AW{1'b0}};
            r_beats_left    <= {(AW+1){1'b0}};
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr       <= cmd_addr;
                r_beats_left <= {1'b0, cmd_len_m1} + {{AW{1'b0}}, 1'b1};
            end else if (w_issue) begin
                r_addr       <= r_addr + {{(AW-1){1'b0}}, 1'b1};
                r_beats_left <= r_beats_left - {{AW{1'b0}}, 1'b1};
            end else begin
                r_addr       <= r_addr;
                r_beats_left <= r_beats_left;
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_beats_left == {{AW{1'b0}}, 1'b1});
        end
    end

endmodule
